// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port system RAM: BIOS (m0) owns it
// during boot, then BIOS and core share it round-robin with read-owner tracking.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_booted,
    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rsp_rdata,
    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rsp_rdata,
    output logic                    o_ram_read_req,
    output logic                    o_ram_write_enable,
    output logic [DATA_WIDTH/8-1:0] o_ram_byte_enable,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_write_data,
    input  logic [DATA_WIDTH-1:0]   i_ram_read_data
);
    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {BOOT, DRAIN, SHARED} mode_t;

    mode_t mode, mode_nxt;
    logic  last_grant;                   // 0 = m0, 1 = m1
    logic  [1:0] gnt, rdy;
    logic  xfer, xfer_port;

    logic [1:0]                 req_we;
    logic [1:0][BE_W-1:0]       req_be;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;

    // Owner tag travels alongside each read; stage RD_LATENCY lines up with read data.
    logic [RD_LATENCY:0] vld_pipe;
    logic [RD_LATENCY:0] tag_pipe;
    logic                pipe_empty;

    assign req_we    = {m1_we, m0_we};
    assign req_be    = {m1_be, m0_be};
    assign req_addr  = {m1_addr, m0_addr};
    assign req_wdata = {m1_wdata, m0_wdata};

    assign pipe_empty = ~|vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode <= BOOT;
        else        mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        gnt      = 2'b00;
        case (mode)
            BOOT: begin
                gnt[0] = m0_valid;
                if (i_booted) mode_nxt = DRAIN;
            end
            DRAIN: begin
                if (!i_booted)      mode_nxt = BOOT;
                else if (pipe_empty) mode_nxt = SHARED;
            end
            SHARED: begin
                if (m0_valid && m1_valid) gnt = last_grant ? 2'b01 : 2'b10;
                else                      gnt = {m1_valid, m0_valid};
                if (!i_booted) mode_nxt = BOOT;
            end
            default: mode_nxt = BOOT;
        endcase
    end

    assign rdy       = gnt & {2{rst_n}};
    assign m0_ready  = rdy[0];
    assign m1_ready  = rdy[1];
    assign xfer      = |rdy;
    assign xfer_port = rdy[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant         <= 1'b1;
            o_ram_read_req     <= 1'b0;
            o_ram_write_enable <= 1'b0;
            o_ram_byte_enable  <= '0;
            o_ram_addr         <= '0;
            o_ram_write_data   <= '0;
            vld_pipe           <= '0;
            tag_pipe           <= '0;
        end else begin
            o_ram_read_req     <= xfer & ~req_we[xfer_port];
            o_ram_write_enable <= xfer &  req_we[xfer_port];
            vld_pipe           <= {vld_pipe[RD_LATENCY-1:0], xfer & ~req_we[xfer_port]};
            tag_pipe           <= {tag_pipe[RD_LATENCY-1:0], xfer_port};
            if (xfer) begin
                last_grant        <= xfer_port;
                o_ram_addr        <= req_addr[xfer_port];
                o_ram_write_data  <= req_wdata[xfer_port];
                o_ram_byte_enable <= req_we[xfer_port] ? req_be[xfer_port] : {BE_W{1'b1}};
            end
        end
    end

    assign m0_rsp_valid = vld_pipe[RD_LATENCY] & ~tag_pipe[RD_LATENCY];
    assign m1_rsp_valid = vld_pipe[RD_LATENCY] &  tag_pipe[RD_LATENCY];
    assign m0_rsp_rdata = i_ram_read_data;
    assign m1_rsp_rdata = i_ram_read_data;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: grant table, directed corner sequences, then random
// traffic against a transaction-level model (shadow memory + expected response queue).
module tb_ram_port_arbiter;
    localparam int L = 1;

    logic        clk = 1'b0, rst_n = 1'b0, i_booted = 1'b0;
    logic        m0_valid, m0_ready, m0_we, m0_rsp_valid;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rsp_rdata;
    logic        m1_valid, m1_ready, m1_we, m1_rsp_valid;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rsp_rdata;
    logic        o_ram_read_req, o_ram_write_enable;
    logic [3:0]  o_ram_byte_enable;
    logic [31:0] o_ram_addr, o_ram_write_data, i_ram_read_data;

    int vecs = 0, errs = 0;

    ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .i_booted(i_booted),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_be(m0_be),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_be(m1_be),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .o_ram_read_req(o_ram_read_req), .o_ram_write_enable(o_ram_write_enable),
        .o_ram_byte_enable(o_ram_byte_enable), .o_ram_addr(o_ram_addr),
        .o_ram_write_data(o_ram_write_data), .i_ram_read_data(i_ram_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        case (k)
            0:       return 32'h11111111;
            1:       return 32'h22222222;
            'h40:    return 32'hDEADBEEF;
            default: return {8'(k), 8'(~k), 16'hC3A5};
        endcase
    endfunction

    // RAM model: byte-masked writes, reads valid L cycles after the strobe cycle.
    logic        ram_init = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [L];
    assign i_ram_read_data = rd_pipe[L-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
        end else if (o_ram_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_byte_enable[b]) mem[o_ram_addr[9:2]][b*8 +: 8] <= o_ram_write_data[b*8 +: 8];
        end
        rd_pipe[0] <= mem[o_ram_addr[9:2]];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        m0_valid = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic step(); @(posedge clk); #1; endtask
    task automatic samp(); @(negedge clk); endtask

    task automatic do_reset();
        idle();
        rst_n = 0; ram_init = 1;
        repeat (2) @(posedge clk);
        #1 ram_init = 0; rst_n = 1;
    endtask

    typedef struct { logic booted; logic v0; logic v1; logic [1:0] rdy; } vec_t;
    typedef struct { bit owner; logic [31:0] data; int due; } rsp_t;

    vec_t        tbl [12];
    rsp_t        rq [$];
    rsp_t        hd;
    logic [31:0] shadow [256];
    int          mmode, cyc, rsp_cyc, gnt_cyc, idx;
    bit          mlast, empty, g0, g1, p, ev0, ev1;
    bit          px, pwe;
    logic [3:0]  pbe;
    logic [31:0] paddr, pwdata, ed;
    logic [1:0]  exp_rr [4];
    logic [31:0] exp_rd [4];

    initial begin
        // reset state, with m0 requesting during reset
        idle(); m0_valid = 1;
        #3;
        chk("reset m0_ready", m0_ready, 0);
        chk("reset read_req", o_ram_read_req, 0);
        chk("reset write_enable", o_ram_write_enable, 0);
        chk("reset byte_enable", o_ram_byte_enable, 0);
        chk("reset addr", o_ram_addr, 0);
        chk("reset rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 0);

        // grant table: write-only traffic, {m1_ready,m0_ready} expected per cycle
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 2'b01};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'b00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'b00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'b00};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b01};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'b10};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'b10};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b01};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'b10};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b01};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b00};
        do_reset();
        m0_we = 1; m1_we = 1; m0_be = 4'hF; m1_be = 4'hF;
        for (int i = 0; i < 12; i++) begin
            i_booted = tbl[i].booted; m0_valid = tbl[i].v0; m1_valid = tbl[i].v1;
            m0_addr = 32'h200 + 32'(i*4); m1_addr = 32'h300 + 32'(i*4);
            samp();
            chk($sformatf("table[%0d] grant", i), {m1_ready, m0_ready}, tbl[i].rdy);
            step();
        end

        // BOOT exclusivity
        do_reset(); i_booted = 0;
        m0_valid = 1; m0_we = 0; m0_addr = 32'h100;
        m1_valid = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h8; m1_wdata = 32'h55;
        samp();
        chk("A m0_ready", m0_ready, 1);
        chk("A m1_ready", m1_ready, 0);
        step(); m0_valid = 0;
        samp();
        chk("A read_req", o_ram_read_req, 1);
        chk("A addr", o_ram_addr, 32'h100);
        chk("A read byte_enable", o_ram_byte_enable, 4'hF);
        step();
        samp();
        chk("A m0_rsp_valid", m0_rsp_valid, 1);
        chk("A m0_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        chk("A m1_rsp_valid", m1_rsp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            chk("A m1_ready", m1_ready, 0);
            chk("A write_enable", o_ram_write_enable, 0);
            step(); samp();
        end
        chk("A mem untouched", mem[2], init_word(2));
        idle();

        // round-robin from reset, both ports valid every cycle
        do_reset(); i_booted = 1;
        repeat (3) step();
        m0_valid = 1; m0_we = 1; m0_be = 4'hF;
        m1_valid = 1; m1_we = 1; m1_be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            m0_addr = 32'h80 + 32'(k*4); m1_addr = 32'hC0 + 32'(k*4);
            samp();
            chk($sformatf("B grant %0d", k), {m1_ready, m0_ready}, (k % 2) ? 2'b10 : 2'b01);
            step();
        end

        // byte write from m1
        m0_valid = 0;
        m1_valid = 1; m1_we = 1; m1_be = 4'b0100; m1_addr = 32'h20; m1_wdata = 32'h00AB0000;
        samp();
        chk("C m1_ready", m1_ready, 1);
        step(); idle();
        samp();
        chk("C write_enable", o_ram_write_enable, 1);
        chk("C read_req", o_ram_read_req, 0);
        chk("C byte_enable", o_ram_byte_enable, 4'b0100);
        chk("C addr", o_ram_addr, 32'h20);
        chk("C wdata", o_ram_write_data, 32'h00AB0000);
        step(); samp();
        chk("C strobe drop", o_ram_write_enable, 0);
        chk("C mem merge", mem[8], (init_word(8) & 32'hFF00FFFF) | 32'h00AB0000);

        // response routing, back-to-back reads (last grant is m1, so m0 first)
        step();
        m0_valid = 1; m0_we = 0; m0_addr = 32'h0;
        m1_valid = 1; m1_we = 0; m1_addr = 32'h4;
        samp(); chk("D m0 first", {m1_ready, m0_ready}, 2'b01);
        step(); m0_valid = 0;
        samp(); chk("D m1 second", {m1_ready, m0_ready}, 2'b10);
        step(); m1_valid = 0;
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b00; exp_rr[3] = 2'b00;
        exp_rd[0] = 32'h11111111; exp_rd[1] = 32'h22222222; exp_rd[2] = 0; exp_rd[3] = 0;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk($sformatf("D rsp_valid %0d", i), {m1_rsp_valid, m0_rsp_valid}, exp_rr[i]);
            if (exp_rr[i] == 2'b01) chk("D m0 rdata", m0_rsp_rdata, exp_rd[i]);
            if (exp_rr[i] == 2'b10) chk("D m1 rdata", m1_rsp_rdata, exp_rd[i]);
            step();
        end

        // DRAIN: boot completes with a read in flight and m1 waiting
        do_reset(); i_booted = 1;
        m0_valid = 1; m0_we = 0; m0_addr = 32'h0;
        m1_valid = 1; m1_we = 0; m1_addr = 32'h4;
        samp();
        chk("E m0_ready", m0_ready, 1);
        chk("E m1_ready", m1_ready, 0);
        step(); m0_valid = 0;
        rsp_cyc = -1; gnt_cyc = -1;
        for (int n = 1; n <= 10; n++) begin
            samp();
            if (m0_rsp_valid) rsp_cyc = n;
            if (m1_ready) begin gnt_cyc = n; break; end
            step();
        end
        chk("E response cycle", rsp_cyc, 1 + L);
        chk("E m1 grant cycle", gnt_cyc, 3 + L);
        step(); idle();

        // async reset with reads in flight
        do_reset(); i_booted = 0;
        m0_valid = 1; m0_we = 0; m0_addr = 32'h0;
        samp(); chk("F m0_ready", m0_ready, 1);
        step(); m0_addr = 32'h4;
        samp(); step(); m0_addr = 32'h8;
        #1;
        chk("F rsp before reset", m0_rsp_valid, 1);
        chk("F read_req before reset", o_ram_read_req, 1);
        #1 rst_n = 0; i_booted = 1;
        #1;
        chk("F read_req in reset", o_ram_read_req, 0);
        chk("F rsp_valid in reset", m0_rsp_valid, 0);
        chk("F m0_ready in reset", m0_ready, 0);
        @(posedge clk); #1 rst_n = 1;
        m0_valid = 0; m1_valid = 1; m1_we = 0; m1_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk($sformatf("F m1_ready %0d", i), m1_ready, (i == 2) ? 1 : 0);
            chk("F stale rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
            step();
        end
        idle();

        // random traffic against the transaction model
        do_reset(); i_booted = 0;
        for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
        rq.delete();
        mmode = 0; mlast = 1; cyc = 0; px = 0; pwe = 0; pbe = 0; paddr = 0; pwdata = 0;
        repeat (3000) begin
            samp();
            empty = (rq.size() == 0);
            ev0 = 0; ev1 = 0; ed = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                hd = rq.pop_front();
                ev0 = !hd.owner; ev1 = hd.owner; ed = hd.data;
            end
            chk("R m0_rsp_valid", m0_rsp_valid, ev0);
            chk("R m1_rsp_valid", m1_rsp_valid, ev1);
            if (ev0) chk("R m0_rsp_rdata", m0_rsp_rdata, ed);
            if (ev1) chk("R m1_rsp_rdata", m1_rsp_rdata, ed);
            chk("R read_req", o_ram_read_req, px & !pwe);
            chk("R write_enable", o_ram_write_enable, px & pwe);
            if (px) begin
                chk("R addr", o_ram_addr, paddr);
                chk("R byte_enable", o_ram_byte_enable, pwe ? pbe : 4'hF);
                if (pwe) chk("R wdata", o_ram_write_data, pwdata);
            end

            g0 = 0; g1 = 0;
            if (mmode == 0) g0 = m0_valid;
            else if (mmode == 2) begin
                if (m0_valid && m1_valid) begin g0 = mlast; g1 = !mlast; end
                else begin g0 = m0_valid; g1 = m1_valid; end
            end
            chk("R grant", {m1_ready, m0_ready}, {g1, g0});

            px = g0 | g1;
            if (px) begin
                p      = g1;
                pwe    = p ? m1_we : m0_we;
                pbe    = p ? m1_be : m0_be;
                paddr  = p ? m1_addr : m0_addr;
                pwdata = p ? m1_wdata : m0_wdata;
                mlast  = p;
                idx    = int'(paddr[9:2]);
                if (pwe) begin
                    for (int b = 0; b < 4; b++)
                        if (pbe[b]) shadow[idx][b*8 +: 8] = pwdata[b*8 +: 8];
                end else begin
                    rq.push_back('{p, shadow[idx], cyc + 1 + L});
                end
            end

            case (mmode)
                0: if (i_booted) mmode = 1;
                1: if (!i_booted) mmode = 0; else if (empty) mmode = 2;
                default: if (!i_booted) mmode = 0;
            endcase
            cyc++;

            step();
            if (g0 || !m0_valid) begin
                m0_valid = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
                m0_be = 4'($urandom); m0_addr = 32'($urandom_range(0, 15)) << 2; m0_wdata = $urandom;
            end
            if (g1 || !m1_valid) begin
                m1_valid = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1));
                m1_be = 4'($urandom); m1_addr = 32'($urandom_range(0, 15)) << 2; m1_wdata = $urandom;
            end
            if ($urandom_range(0, 49) == 0) i_booted = !i_booted;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
